// File: rtl/bus_mux_pipe.sv
// Registered datapath bus multiplexer: lowest-index priority select, bus keeper,
// and sticky contention detection with a saturating event counter. Optional macro BUS_PARITY_EN adds bus_parity.
module bus_mux_pipe #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_SRC   = 24,
  parameter int CNT_W     = 8,
  localparam int SEL_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic [NUM_SRC*WORD_SIZE-1:0]  src_data,
  input  logic [NUM_SRC-1:0]            src_en,
  input  logic                          clr_err,
  output logic [WORD_SIZE-1:0]          bus_out,
  output logic                          bus_valid,
  output logic [SEL_W-1:0]              sel_idx,
  output logic                          contention,
  output logic [CNT_W-1:0]              contention_cnt
`ifdef BUS_PARITY_EN
  ,
  output logic                          bus_parity
`endif
);

  logic [SEL_W-1:0]     w_idx;
  logic [WORD_SIZE-1:0] w_word;
  logic                 w_any;
  logic                 w_multi;

  logic [WORD_SIZE-1:0] r_bus;
  logic [SEL_W-1:0]     r_sel;
  logic                 r_valid;
  logic                 r_cont;
  logic [CNT_W-1:0]     r_cnt;

  // Scan from the top down so the lowest enabled index is the last one written.
  always_comb begin
    w_idx  = '0;
    w_word = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_en[i]) begin
        w_idx  = SEL_W'(i);
        w_word = src_data[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  assign w_any   = |src_en;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi = |(src_en & (src_en - NUM_SRC'(1)));

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_bus   <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_any;
      if (w_any) begin
        r_bus <= w_word;
        r_sel <= w_idx;
      end
    end
  end

  // A contention event in the same cycle as clr_err wins over the clear.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_cont <= 1'b0;
      r_cnt  <= '0;
    end else if (w_multi) begin
      r_cont <= 1'b1;
      if (clr_err)
        r_cnt <= CNT_W'(1);
      else if (r_cnt != {CNT_W{1'b1}})
        r_cnt <= r_cnt + CNT_W'(1);
    end else if (clr_err) begin
      r_cont <= 1'b0;
      r_cnt  <= '0;
    end
  end

`ifdef BUS_PARITY_EN
  logic r_par;

  always_ff @(posedge clock or posedge clear) begin
    if (clear)
      r_par <= 1'b0;
    else if (w_any)
      r_par <= ^w_word;
  end

  assign bus_parity = r_par;
`endif

  assign bus_out        = r_bus;
  assign bus_valid      = r_valid;
  assign sel_idx        = r_sel;
  assign contention     = r_cont;
  assign contention_cnt = r_cnt;

endmodule

// File: tb/tb_bus_mux_pipe.sv
// Bench for bus_mux_pipe: reference model checked every cycle plus directed literal pins.
module tb_bus_mux_pipe;
  localparam int WORD_SIZE = 32;
  localparam int NUM_SRC   = 24;
  localparam int CNT_W     = 8;
  localparam int SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic                         clock = 1'b0;
  logic                         clear = 1'b1;
  logic [NUM_SRC*WORD_SIZE-1:0] src_data = '0;
  logic [NUM_SRC*WORD_SIZE-1:0] data_nx  = '0;
  logic [NUM_SRC-1:0]           src_en   = '0;
  logic                         clr_err  = 1'b0;
  logic [WORD_SIZE-1:0]         bus_out;
  logic                         bus_valid;
  logic [SEL_W-1:0]             sel_idx;
  logic                         contention;
  logic [CNT_W-1:0]             contention_cnt;
`ifdef BUS_PARITY_EN
  logic                         bus_parity;
`endif

  int n_pass  = 0;
  int n_total = 0;

  bus_mux_pipe #(.WORD_SIZE(WORD_SIZE), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .clear          (clear),
    .src_data       (src_data),
    .src_en         (src_en),
    .clr_err        (clr_err),
    .bus_out        (bus_out),
    .bus_valid      (bus_valid),
    .sel_idx        (sel_idx),
    .contention     (contention),
    .contention_cnt (contention_cnt)
`ifdef BUS_PARITY_EN
    ,
    .bus_parity     (bus_parity)
`endif
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [WORD_SIZE-1:0] m_bus   = '0;
  int                   m_sel   = 0;
  logic                 m_valid = 1'b0;
  logic                 m_cont  = 1'b0;
  int                   m_cnt   = 0;

  function automatic int first_en(input logic [NUM_SRC-1:0] en);
    for (int i = 0; i < NUM_SRC; i++)
      if (en[i]) return i;
    return -1;
  endfunction

  always @(posedge clock or posedge clear) begin
    int k;
    int drivers;
    if (clear) begin
      m_bus   <= '0;
      m_sel   <= 0;
      m_valid <= 1'b0;
      m_cont  <= 1'b0;
      m_cnt   <= 0;
    end else begin
      k       = first_en(src_en);
      drivers = $countones(src_en);
      m_valid <= (drivers > 0);
      if (drivers > 0) begin
        m_bus <= src_data[k*WORD_SIZE +: WORD_SIZE];
        m_sel <= k;
      end
      if (drivers >= 2) begin
        m_cont <= 1'b1;
        m_cnt  <= clr_err ? 1 : ((m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1);
      end else if (clr_err) begin
        m_cont <= 1'b0;
        m_cnt  <= 0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clock) begin
    check("model bus_out",        64'(bus_out),        64'(m_bus));
    check("model bus_valid",      64'(bus_valid),      64'(m_valid));
    check("model sel_idx",        64'(sel_idx),        64'(m_sel));
    check("model contention",     64'(contention),     64'(m_cont));
    check("model contention_cnt", 64'(contention_cnt), 64'(m_cnt));
`ifdef BUS_PARITY_EN
    check("model bus_parity",     64'(bus_parity),     64'(^m_bus));
`endif
  end

  // ---------------- driver ----------------
  // Inputs change 2 time units after an edge and are sampled at the next edge,
  // so after step() returns the outputs reflect the previous step's inputs.
  task automatic step(input logic [NUM_SRC-1:0] en, input logic ce);
    @(posedge clock);
    #2;
    src_en   = en;
    clr_err  = ce;
    src_data = data_nx;
  endtask

  task automatic check_all(input string tag, input logic [WORD_SIZE-1:0] b, input logic v,
                           input int s, input logic c, input int n);
    check({tag, " bus_out"},        64'(bus_out),        64'(b));
    check({tag, " bus_valid"},      64'(bus_valid),      64'(v));
    check({tag, " sel_idx"},        64'(sel_idx),        64'(s));
    check({tag, " contention"},     64'(contention),     64'(c));
    check({tag, " contention_cnt"}, 64'(contention_cnt), 64'(n));
  endtask

  // ---------------- stimulus ----------------
  localparam logic [NUM_SRC-1:0] ONE = NUM_SRC'(1);

  initial begin
    logic [NUM_SRC-1:0] en39;
    en39 = (ONE << 3) | (ONE << 9);

    #17 clear = 1'b0;
    repeat (5) begin
      step('0, 1'b0);
      check_all("idle", '0, 1'b0, 0, 1'b0, 0);
    end

    data_nx[17*WORD_SIZE +: WORD_SIZE] = 32'hDEADBEEF;
    step(ONE << 17, 1'b0);
    step('0, 1'b0);
    check_all("single", 32'hDEADBEEF, 1'b1, 17, 1'b0, 0);
    step('0, 1'b0);
    check_all("keeper", 32'hDEADBEEF, 1'b0, 17, 1'b0, 0);

    data_nx[3*WORD_SIZE +: WORD_SIZE] = 32'h11111111;
    data_nx[9*WORD_SIZE +: WORD_SIZE] = 32'h22222222;
    step(en39, 1'b0);
    step(en39, 1'b0);
    step('0, 1'b0);
    check_all("contend", 32'h11111111, 1'b1, 3, 1'b1, 2);

    data_nx[23*WORD_SIZE +: WORD_SIZE] = 32'hA5A50023;
    data_nx[0 +: WORD_SIZE]            = 32'h0BADF00D;
    step(ONE << 23, 1'b0);
    step(ONE | (ONE << 23), 1'b0);
    check_all("top src", 32'hA5A50023, 1'b1, 23, 1'b1, 2);
    step('0, 1'b0);
    check_all("src0 win", 32'h0BADF00D, 1'b1, 0, 1'b1, 3);

    data_nx[5*WORD_SIZE +: WORD_SIZE] = 32'h55AA0001;
    repeat (300) step(en39, 1'b0);
    step(ONE << 5, 1'b1);
    check_all("saturate", 32'h11111111, 1'b1, 3, 1'b1, 255);
    step('0, 1'b0);
    check_all("clr single", 32'h55AA0001, 1'b1, 5, 1'b0, 0);
    step(en39, 1'b1);
    step('0, 1'b0);
    check_all("clr vs multi", 32'h11111111, 1'b1, 3, 1'b1, 1);

    step(ONE << 5, 1'b0);
    step(ONE << 5, 1'b0);
    check_all("pre reset", 32'h55AA0001, 1'b1, 5, 1'b1, 1);
    #1 clear = 1'b1;
    #1 check_all("async reset", '0, 1'b0, 0, 1'b0, 0);
    #3 clear = 1'b0;
    @(posedge clock);
    #2 check_all("post reset", 32'h55AA0001, 1'b1, 5, 1'b0, 0);

`ifdef BUS_PARITY_EN
    data_nx[1*WORD_SIZE +: WORD_SIZE] = 32'h00000007;
    data_nx[2*WORD_SIZE +: WORD_SIZE] = 32'h00000003;
    step(ONE << 1, 1'b0);
    step(ONE << 2, 1'b0);
    check("parity 7", 64'(bus_parity), 64'(1));
    step('0, 1'b0);
    check("parity 3", 64'(bus_parity), 64'(0));
    step('0, 1'b0);
    check("parity hold", 64'(bus_parity), 64'(0));
`endif

    repeat (3) step('0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_mux_pipe.md
Name: bus_mux_pipe

Overview:
- Parametrised, registered successor to the datapath bus multiplexer.
- Selects one of NUM_SRC word-wide sources onto the shared datapath bus from the control unit's one-hot "out" strobes, using a priority encoder.
- Registers the result and keeps the last driven value when no source is enabled.
- Detects multi-driver contention, holds it in a sticky flag and counts the events for debug.
- Sits between the register file, special registers (HI, LO, Z, PC, MDR, InPort, C) and every bus consumer.

Parameters:
- WORD_SIZE, 32, bus width in bits.
- NUM_SRC, 24, number of bus sources; legal range 2..64.
- CNT_W, 8, width of the contention event counter.
- Derived localparam SEL_W = clog2(NUM_SRC), minimum 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- src_data  in  NUM_SRC*WORD_SIZE  flattened source words; source i occupies bits [i*WORD_SIZE +: WORD_SIZE].
- src_en  in  NUM_SRC  per-source out-enable strobes; one-hot expected.
- clr_err  in  1  synchronous clear of contention and contention_cnt.
- bus_out  out  WORD_SIZE  registered bus value (BusMuxOut).
- bus_valid  out  1  high for one cycle after any src_en was asserted.
- sel_idx  out  SEL_W  index of the source currently held on bus_out.
- contention  out  1  sticky flag: two or more src_en were asserted in some cycle.
- contention_cnt  out  CNT_W  saturating count of contention cycles.

Behaviour:
- Reset (clear=1, asynchronous): bus_out=0, bus_valid=0, sel_idx=0, contention=0, contention_cnt=0. Reset overrides every other input, including mid-transfer.
- Encode (combinational): idx = lowest i with src_en[i]=1; any_en = OR-reduction of src_en; multi = (popcount(src_en) >= 2).
- Latency: exactly 1 clock from src_en/src_data sampled to bus_out/sel_idx/bus_valid.
- Rising edge with any_en=1: bus_out <= src_data slice idx; sel_idx <= idx; bus_valid <= 1.
- Rising edge with any_en=0 (bus keeper): bus_out and sel_idx hold their values; bus_valid <= 0.
- Contention: on a rising edge with multi=1, contention <= 1 and contention_cnt increments, saturating at 2^CNT_W-1 (no wrap). The lowest-index source still wins the bus.
- clr_err=1 on an edge: contention <= 0 and contention_cnt <= 0, unless multi=1 in the same cycle; the new event wins, giving contention=1 and contention_cnt=1.
- clr_err affects neither bus_out, bus_valid nor sel_idx.
- Source index NUM_SRC-1 is selectable. Bits of src_en are never out of range because the port width equals NUM_SRC.
- No combinational path from any input to any output.

Optional Feature:
- Macro BUS_PARITY_EN.
- When defined: extra output port bus_parity (1 bit), registered alongside bus_out. It equals the XOR of the word loaded into bus_out and holds with bus_out during keeper cycles. Reset value 0.
- When undefined: port absent, no parity logic.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then idle: clear pulse, src_en=0 for 5 cycles -> bus_out=0, bus_valid=0, sel_idx=0, contention=0, contention_cnt=0 throughout.
- Single source with 1-cycle latency: src 17 = 0xDEADBEEF, src_en=1<<17 for one cycle -> next edge bus_out=0xDEADBEEF, sel_idx=17, bus_valid=1; following idle cycle bus_valid=0, bus_out holds 0xDEADBEEF.
- Contention priority: src 3 = 0x11111111, src 9 = 0x22222222, src_en=(1<<3)|(1<<9) for 2 cycles -> bus_out=0x11111111, sel_idx=3, contention=1, contention_cnt=2.
- Counter saturation and clear: CNT_W=8, multi-driver held for 300 cycles -> contention_cnt=255. Then clr_err=1 with single driver -> counter 0, flag 0. Then clr_err=1 with a simultaneous multi-driver cycle -> contention=1, contention_cnt=1.
- Reset mid-operation: clear asserted asynchronously between edges while src_en=1<<5 -> outputs go to 0 immediately, without waiting for a clock edge. After release, the next edge loads src 5.
- Parity (BUS_PARITY_EN defined): load 0x00000007 -> bus_parity=1; load 0x00000003 -> bus_parity=0; idle cycle -> bus_parity holds 0.
